decoding_block_scheduler: RTL

Per-block sequencer in front of the decoding processor. It walks the 8x2 block grid of one slice and accepts parsed blocks from the substream parser. For each block it issues the neighbours-above read to the pixel buffer and waits for the reconstructed block. It generates all position flags (sos, eos, soc, eoc, fbls, resetLeft, eob) and prevBlockMode that the datapath consumes.

---
 rtl/decoding_block_scheduler.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/decoding_block_scheduler.sv
// decoding_block_scheduler: per-block sequencer walking the 8x2 block grid of a slice ahead of the decoding processor.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   flush                       synchronous abort back to the reset state
//   slice_start, slice_width, slice_height   new slice and its size (sampled on the pulse)
//   blk_valid / blk_ready, blockMode_in      block handshake with the substream parser
//   stall_pull                  pixel buffer back-pressure
//   neighborsAbove_rd_en / neighborsAbove_valid   neighbours-above read request and return
//   pReconBlk_valid             reconstructed block available
//   blockMode, prevBlockMode    mode of the block in flight and of the last completed block
//   sos, eos, soc, eoc, fbls, resetLeft   position flags of the block in flight
//   eob, slice_done             completion pulses for the block and for the slice
//   blk_x, blk_y                current block column and row
//   err                         sticky protocol error
module decoding_block_scheduler #(
    parameter int MAX_SLICE_WIDTH  = 2560,
    parameter int MAX_SLICE_HEIGHT = 4096
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  flush,
    input  logic                                  slice_start,
    input  logic [$clog2(MAX_SLICE_WIDTH)-1:0]    slice_width,
    input  logic [$clog2(MAX_SLICE_HEIGHT)-1:0]   slice_height,
    input  logic                                  blk_valid,
    output logic                                  blk_ready,
    input  logic [2:0]                            blockMode_in,
    input  logic                                  stall_pull,
    output logic                                  neighborsAbove_rd_en,
    input  logic                                  neighborsAbove_valid,
    input  logic                                  pReconBlk_valid,
    output logic [2:0]                            blockMode,
    output logic [2:0]                            prevBlockMode,
    output logic                                  sos,
    output logic                                  eos,
    output logic                                  soc,
    output logic                                  eoc,
    output logic                                  fbls,
    output logic                                  resetLeft,
    output logic                                  eob,
    output logic [$clog2(MAX_SLICE_WIDTH)-4:0]    blk_x,
    output logic [$clog2(MAX_SLICE_HEIGHT)-2:0]   blk_y,
    output logic                                  slice_done,
    output logic                                  err
);
    localparam int WW = $clog2(MAX_SLICE_WIDTH);
    localparam int HW = $clog2(MAX_SLICE_HEIGHT);
    localparam int XW = WW - 3;
    localparam int YW = HW - 1;
    // Blocks per row can reach 2^(WW-3), so it needs one bit more than blk_x.
    localparam int BW = WW - 2;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_WAIT_BLK   = 3'd1;
    localparam logic [2:0] S_RD_NBR     = 3'd2;
    localparam logic [2:0] S_WAIT_NBR   = 3'd3;
    localparam logic [2:0] S_WAIT_RECON = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [BW-1:0] bpr_q, bpr_d;
    logic [HW-1:0] rows_q, rows_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [2:0]    mode_q, mode_d, prev_q, prev_d;
    logic          sos_q, sos_d, eos_q, eos_d, soc_q, soc_d, eoc_q, eoc_d, fbls_q, fbls_d;
    logic          eob_q, eob_d, done_q, done_d, err_q, err_d;
    logic [WW:0]   bpr_sum;
    logic [HW:0]   rows_sum;
    logic          last_col, last_row;

    assign bpr_sum  = {1'b0, slice_width} + (WW+1)'(7);
    assign rows_sum = {1'b0, slice_height} + (HW+1)'(1);
    assign last_col = BW'(x_q) == bpr_q - BW'(1);
    assign last_row = HW'(y_q) == rows_q - HW'(1);

    assign blk_ready            = (state_q == S_WAIT_BLK) && !stall_pull;
    assign neighborsAbove_rd_en = state_q == S_RD_NBR;
    assign blockMode            = mode_q;
    assign prevBlockMode        = prev_q;
    assign sos                  = sos_q;
    assign eos                  = eos_q;
    assign soc                  = soc_q;
    assign resetLeft            = soc_q;
    assign eoc                  = eoc_q;
    assign fbls                 = fbls_q;
    assign eob                  = eob_q;
    assign slice_done           = done_q;
    assign blk_x                = x_q;
    assign blk_y                = y_q;
    assign err                  = err_q;

    always_comb begin
        state_d = state_q;
        bpr_d   = bpr_q;
        rows_d  = rows_q;
        x_d     = x_q;
        y_d     = y_q;
        mode_d  = mode_q;
        prev_d  = prev_q;
        sos_d   = sos_q;
        eos_d   = eos_q;
        soc_d   = soc_q;
        eoc_d   = eoc_q;
        fbls_d  = fbls_q;
        eob_d   = 1'b0;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (slice_start) begin
                    if (slice_width == '0 || slice_height == '0) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_WAIT_BLK;
                        bpr_d   = bpr_sum[WW:3];
                        rows_d  = rows_sum[HW:1];
                        x_d     = '0;
                        y_d     = '0;
                    end
                end
            end
            S_WAIT_BLK: begin
                if (blk_valid && blk_ready) begin
                    state_d = S_RD_NBR;
                    mode_d  = blockMode_in;
                    sos_d   = x_q == '0 && y_q == '0;
                    eos_d   = last_col && last_row;
                    soc_d   = x_q == '0;
                    eoc_d   = last_col;
                    fbls_d  = y_q == '0;
                end
            end
            // Read data returned together with the request skips the wait state.
            S_RD_NBR:   state_d = neighborsAbove_valid ? S_WAIT_RECON : S_WAIT_NBR;
            S_WAIT_NBR: state_d = neighborsAbove_valid ? S_WAIT_RECON : S_WAIT_NBR;
            S_WAIT_RECON: begin
                if (pReconBlk_valid) begin
                    eob_d  = 1'b1;
                    prev_d = mode_q;
                    if (eos_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        x_d     = '0;
                        y_d     = '0;
                        mode_d  = '0;
                        sos_d   = 1'b0;
                        eos_d   = 1'b0;
                        soc_d   = 1'b0;
                        eoc_d   = 1'b0;
                        fbls_d  = 1'b0;
                    end else begin
                        state_d = S_WAIT_BLK;
                        x_d     = last_col ? '0 : x_q + XW'(1);
                        y_d     = last_col ? y_q + YW'(1) : y_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (pReconBlk_valid && state_q != S_WAIT_RECON)
            err_d = 1'b1;
        if (neighborsAbove_valid && state_q != S_RD_NBR && state_q != S_WAIT_NBR)
            err_d = 1'b1;
        if (slice_start && state_q != S_IDLE)
            err_d = 1'b1;
        // Flush overrides everything above, including a coincident slice_start.
        if (flush) begin
            state_d = S_IDLE;
            bpr_d   = '0;
            rows_d  = '0;
            x_d     = '0;
            y_d     = '0;
            mode_d  = '0;
            prev_d  = '0;
            sos_d   = 1'b0;
            eos_d   = 1'b0;
            soc_d   = 1'b0;
            eoc_d   = 1'b0;
            fbls_d  = 1'b0;
            eob_d   = 1'b0;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            bpr_q   <= '0;
            rows_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            mode_q  <= '0;
            prev_q  <= '0;
            sos_q   <= 1'b0;
            eos_q   <= 1'b0;
            soc_q   <= 1'b0;
            eoc_q   <= 1'b0;
            fbls_q  <= 1'b0;
            eob_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bpr_q   <= bpr_d;
            rows_q  <= rows_d;
            x_q     <= x_d;
            y_q     <= y_d;
            mode_q  <= mode_d;
            prev_q  <= prev_d;
            sos_q   <= sos_d;
            eos_q   <= eos_d;
            soc_q   <= soc_d;
            eoc_q   <= eoc_d;
            fbls_q  <= fbls_d;
            eob_q   <= eob_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
endmodule
